// File: rtl/core_sequencer_if.sv
// Instruction-memory and core-side bus of the run/step/halt sequencer.
// The master side is the sequencer: it drives the ROM address and strobe and
// hands the fetched instruction and the clock enable to the core. The slave
// side is the core and ROM: they return the read data and the current PC.
interface core_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [31:0]       imem_data;
  logic [31:0]       pc_address;
  logic [31:0]       instr;
  logic              core_en;

  modport master (
    output imem_addr,
    output imem_rd_en,
    output instr,
    output core_en,
    input  imem_data,
    input  pc_address
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    input  instr,
    input  core_en,
    output imem_data,
    output pc_address
  );
endinterface

// File: rtl/core_sequencer.sv
// Run/step/halt controller for the single-cycle core.
// Each instruction takes three cycles. FETCH presents the PC-derived ROM
// address. WAIT latches the ROM data into instr. EXEC pulses core_en for one
// cycle. Debug halt, single-step, one PC breakpoint and a HALT-opcode stop
// all return the sequencer to HALTED. A free-running counter counts the
// retired instructions.
module core_sequencer #(
  parameter int          ADDR_W     = 8,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h00100073,
  parameter bit          START_RUN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  core_sequencer_if.master   bus,
  output logic               halted,
  output logic               bp_hit,
  output logic               halt_hit,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [31:0]      NOP_INSTR = 32'h00000013;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_HALTED,
    S_FETCH,
    S_WAIT,
    S_EXEC
  } state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic        step_mode;
  logic        skip_bp;
  logic        bp_match;

  // The breakpoint fires only on an armed fetch. skip_bp disarms the first
  // fetch after a resume, so resuming at the breakpoint PC executes that
  // instruction.
  assign bp_match = bp_en && (bus.pc_address == bp_addr) && !skip_bp;

  // The strobes decode directly from the state register. This makes core_en
  // collapse the moment an asynchronous reset forces the state away from EXEC.
  assign bus.imem_rd_en = (state == S_FETCH);
  assign bus.imem_addr  = bus.pc_address[ADDR_W+1:2];
  assign bus.core_en    = (state == S_EXEC);
  assign bus.instr      = instr_q;
  assign halted         = (state == S_HALTED);

  // Sequencer FSM. It holds the state, the latched instruction, the sticky
  // halt causes, the step and breakpoint-skip flags, and the retired count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= START_RUN ? S_FETCH : S_HALTED;
      instr_q     <= NOP_INSTR;
      bp_hit      <= 1'b0;
      halt_hit    <= 1'b0;
      instr_count <= '0;
      step_mode   <= 1'b0;
      skip_bp     <= 1'b0;
    end else begin
      case (state)
        S_HALTED: begin
          if (halt_req) begin
            state <= S_HALTED;
          end else if (step_req) begin
            state     <= S_FETCH;
            step_mode <= 1'b1;
            skip_bp   <= 1'b1;
            bp_hit    <= 1'b0;
            halt_hit  <= 1'b0;
          end else if (run_req) begin
            state     <= S_FETCH;
            step_mode <= 1'b0;
            skip_bp   <= 1'b1;
            bp_hit    <= 1'b0;
            halt_hit  <= 1'b0;
          end
        end
        S_FETCH: begin
          skip_bp <= 1'b0;
          if (halt_req) begin
            state <= S_HALTED;
          end else if (bp_match) begin
            state  <= S_HALTED;
            bp_hit <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          instr_q <= bus.imem_data;
          if (halt_req) begin
            state <= S_HALTED;
          end else if (bus.imem_data == HALT_INSTR) begin
            state    <= S_HALTED;
            halt_hit <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          instr_count <= instr_count + CNT_ONE;
          if (halt_req || step_mode) begin
            state <= S_HALTED;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer.
// The bench plays the part of the core and the ROM. The core's PC advances by
// 4 on each core_en pulse, and the ROM returns data one cycle after each read.
// An instruction-level model predicts where each resume stops, why it stops,
// and how many cycles that takes.
module tb_core_sequencer;

  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, step_req, halt_req, bp_en;
  logic [31:0] bp_addr;
  logic        halted, bp_hit, halt_hit;
  logic [31:0] instr_count;
  logic        halted4, bp_hit4, halt_hit4;
  logic [3:0]  instr_count4;

  logic [31:0] rom [256];
  logic [31:0] rom_q;
  logic [31:0] core_pc;
  logic        prev_core_en = 1'b0;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] m_pc;
  int          m_count;
  logic        m_bp, m_halt;
  logic [31:0] m_instr;
  int          m_cycles;

  core_sequencer_if #(.ADDR_W(8)) bus ();
  core_sequencer_if #(.ADDR_W(8)) bus4 ();

  core_sequencer dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .bus(bus),
    .halted(halted), .bp_hit(bp_hit), .halt_hit(halt_hit),
    .instr_count(instr_count)
  );

  core_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .bus(bus4),
    .halted(halted4), .bp_hit(bp_hit4), .halt_hit(halt_hit4),
    .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  assign bus.imem_data   = rom_q;
  assign bus.pc_address  = core_pc;
  assign bus4.imem_data  = rom_q;
  assign bus4.pc_address = core_pc;

  // The ROM has a one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_rd_en) rom_q <= rom[bus.imem_addr];
  end

  // The core model steps its PC to the next word on each clock-enable pulse.
  always @(posedge clk or negedge rst) begin
    if (!rst) core_pc <= 32'h0;
    else if (bus.core_en) core_pc <= core_pc + 32'd4;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Checks made on every cycle: an executed instruction is the word at the
  // current PC and is never the HALT opcode, core_en never repeats on
  // consecutive cycles, and the fetch address tracks the PC.
  always @(negedge clk) begin
    if (bus.core_en) begin
      checkOutput("exec_instr", bus.instr, rom[core_pc[9:2]]);
      checkOutput("exec_not_halt_op", {31'b0, bus.instr == HALT}, 32'd0);
      checkOutput("core_en_single", {31'b0, prev_core_en}, 32'd0);
    end
    if (bus.imem_rd_en) checkOutput("imem_addr", {24'b0, bus.imem_addr}, {24'b0, core_pc[9:2]});
    prev_core_en <= bus.core_en;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic run, input logic step, input logic halt);
    run_req  = run;
    step_req = step;
    halt_req = halt;
    tick();
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic applyReset();
    rst      = 1'b0;
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic fillRom();
    for (int i = 0; i < 256; i++) rom[i] = ($urandom & 32'hFFF0_0000) | NOP;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_core_en"}, {31'b0, bus.core_en}, 32'd0);
    checkOutput({tag, "_rd_en"}, {31'b0, bus.imem_rd_en}, 32'd0);
    checkOutput({tag, "_halted"}, {31'b0, halted}, 32'd1);
    checkOutput({tag, "_instr"}, bus.instr, NOP);
    checkOutput({tag, "_bp_hit"}, {31'b0, bp_hit}, 32'd0);
    checkOutput({tag, "_halt_hit"}, {31'b0, halt_hit}, 32'd0);
    checkOutput({tag, "_count"}, instr_count, 32'd0);
    checkOutput({tag, "_count4"}, {28'b0, instr_count4}, 32'd0);
  endtask

  // Counts the cycles until the sequencer is halted again. The request cycle
  // counts as cycle 1.
  task automatic waitHalted(input int budget, output int cycles);
    cycles = 1;
    while (!halted && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!halted) checkOutput("halt_timeout", {31'b0, halted}, 32'd1);
  endtask

  // Instruction-level reference model. It walks the program from the model
  // PC and stops on a breakpoint (never on the first fetch of a resume), on
  // the HALT opcode, or after one instruction when stepping. It also gives
  // the expected cycle count: three cycles per retired instruction plus the
  // cost of the stop.
  task automatic modelResume(input bit is_step);
    bit first = 1'b1;
    int k = 0;
    bit done = 1'b0;
    m_bp   = 1'b0;
    m_halt = 1'b0;
    for (int guard = 0; guard < 600 && !done; guard++) begin
      if (bp_en && m_pc == bp_addr && !first) begin
        m_bp = 1'b1; m_cycles = 2 + 3 * k; done = 1'b1;
      end else if (rom[m_pc[9:2]] == HALT) begin
        m_instr = HALT; m_halt = 1'b1; m_cycles = 3 + 3 * k; done = 1'b1;
      end else begin
        m_instr = rom[m_pc[9:2]];
        m_count++;
        m_pc += 32'd4;
        k++;
        first = 1'b0;
        if (is_step) begin
          m_cycles = 1 + 3 * k; done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int cyc;
    int n;
    bit is_step;

    fillRom();
    rst = 1'b0;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b1;
    @(negedge clk);

    // Free run: core_en on every third cycle, then stop on HALT at word 4.
    rom[4] = HALT;
    run_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) run_req = 1'b0;
      checkOutput("t1_core_en_cadence", {31'b0, bus.core_en}, {31'b0, (c % 3) == 0});
    end
    tick();
    checkOutput("t1_count_4", instr_count, 32'd4);
    waitHalted(50, cyc);
    checkOutput("t1_halt_hit", {31'b0, halt_hit}, 32'd1);
    checkOutput("t1_pc", core_pc, 32'h10);

    // A single step executes exactly one instruction and halts again.
    applyReset();
    fillRom();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_running", {31'b0, halted}, 32'd0);
    tick();
    tick();
    checkOutput("t2_core_en", {31'b0, bus.core_en}, 32'd1);
    tick();
    checkOutput("t2_halted", {31'b0, halted}, 32'd1);
    checkOutput("t2_count", instr_count, 32'd1);
    checkOutput("t2_pc", core_pc, 32'h4);

    // A breakpoint at 0x8 stops the run. Resuming executes 0x8 and runs on
    // to the HALT at word 6.
    applyReset();
    fillRom();
    rom[6] = HALT;
    bp_en = 1'b1;
    bp_addr = 32'h8;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitHalted(100, cyc);
    checkOutput("t3_cycles", cyc, 32'd8);
    checkOutput("t3_bp_hit", {31'b0, bp_hit}, 32'd1);
    checkOutput("t3_halt_hit", {31'b0, halt_hit}, 32'd0);
    checkOutput("t3_count", instr_count, 32'd2);
    checkOutput("t3_pc", core_pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitHalted(100, cyc);
    checkOutput("t3_resume_cycles", cyc, 32'd15);
    checkOutput("t3_resume_bp_hit", {31'b0, bp_hit}, 32'd0);
    checkOutput("t3_resume_halt_hit", {31'b0, halt_hit}, 32'd1);
    checkOutput("t3_resume_count", instr_count, 32'd6);
    checkOutput("t3_resume_pc", core_pc, 32'h18);

    // A HALT opcode at word 2 stops the run and stops it again on re-run.
    applyReset();
    fillRom();
    rom[2] = HALT;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitHalted(100, cyc);
    checkOutput("t4_cycles", cyc, 32'd9);
    checkOutput("t4_count", instr_count, 32'd2);
    checkOutput("t4_halt_hit", {31'b0, halt_hit}, 32'd1);
    checkOutput("t4_pc", core_pc, 32'h8);
    checkOutput("t4_instr", bus.instr, HALT);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitHalted(100, cyc);
    checkOutput("t4_rerun_cycles", cyc, 32'd3);
    checkOutput("t4_rerun_count", instr_count, 32'd2);
    checkOutput("t4_rerun_halt_hit", {31'b0, halt_hit}, 32'd1);

    // Debug halt in WAIT, then in EXEC, then together with step while halted.
    applyReset();
    fillRom();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checkOutput("t5_wait_halted", {31'b0, halted}, 32'd1);
    checkOutput("t5_wait_count", instr_count, 32'd0);
    checkOutput("t5_wait_instr", bus.instr, rom[0]);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t5_exec_core_en", {31'b0, bus.core_en}, 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checkOutput("t5_exec_halted", {31'b0, halted}, 32'd1);
    checkOutput("t5_exec_count", instr_count, 32'd1);
    checkOutput("t5_exec_pc", core_pc, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t5_halt_step_halted", {31'b0, halted}, 32'd1);
      tick();
    end
    checkOutput("t5_halt_step_count", instr_count, 32'd1);

    // Seventeen retires wrap the 4-bit counter to 1.
    applyReset();
    fillRom();
    rom[17] = HALT;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitHalted(100, cyc);
    checkOutput("t6_count32", instr_count, 32'd17);
    checkOutput("t6_count4_wrap", {28'b0, instr_count4}, 32'd1);
    checkOutput("t6_pc", core_pc, 32'd68);

    // Reset asserted during EXEC drops core_en at once.
    applyReset();
    fillRom();
    run_req = 1'b1;
    n = 0;
    while (!bus.core_en && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t6_reached_exec", {31'b0, bus.core_en}, 32'd1);
    rst = 1'b0;
    #1;
    checkResetState("t6_midexec");
    run_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Random programs and resumes, checked against the instruction model.
    for (int iter = 0; iter < 8; iter++) begin
      applyReset();
      fillRom();
      for (int i = 0; i < 256; i++) if ($urandom_range(0, 15) == 0) rom[i] = HALT;
      rom[255] = HALT;
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = 32'($urandom_range(0, 24)) * 32'd4;
      m_pc    = 32'h0;
      m_count = 0;
      m_instr = NOP;
      for (int r = 0; r < 5; r++) begin
        is_step = ($urandom_range(0, 2) == 0);
        modelResume(is_step);
        applyStimulus(!is_step, is_step, 1'b0);
        waitHalted(800, cyc);
        checkOutput("rnd_cycles", cyc, m_cycles);
        checkOutput("rnd_pc", core_pc, m_pc);
        checkOutput("rnd_count", instr_count, m_count);
        checkOutput("rnd_count4", {28'b0, instr_count4}, m_count & 15);
        checkOutput("rnd_bp_hit", {31'b0, bp_hit}, {31'b0, m_bp});
        checkOutput("rnd_halt_hit", {31'b0, halt_hit}, {31'b0, m_halt});
        checkOutput("rnd_instr", bus.instr, m_instr);
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
